hyperbus_arbiter: RTL
=====================

// Module: hyperbus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one hyperbus controller between NREQ requesters.
//  Latches the winner's command, holds rrq/wrq stable for the whole transaction,
//  returns read data, completion and error to the granted requester only.
//  Sits between system masters and the controller's adr_i/dat_i/rrq/wrq/busy.
// PARAMETERS
//  NREQ        2    number of requesters (2..8)
//  WIDTH       8    HyperBus DQ width; data words are 2*WIDTH bits
//  ACK_TIMEOUT 15   clk90 cycles allowed from issue until hb_busy rises
// PORTS
//  clk90          in   1             clock (90-degree memory clock), all logic rising edge
//  rst            in   1             asynchronous, active-high reset
//  req_rrq        in   NREQ          per-requester read request, level, held until done
//  req_wrq        in   NREQ          per-requester write request, level, held until done
//  req_reg_space  in   NREQ          per-requester register-space select
//  req_adr        in   NREQ*32       per-requester address, requester i at [32i+31:32i]
//  req_dat        in   NREQ*2*WIDTH  per-requester write data
//  gnt            out  NREQ          one-hot grant, high for issue..done of granted request
//  done           out  NREQ          one-cycle completion pulse to granted requester
//  err            out  NREQ          one-cycle error pulse to granted requester
//  rdat           out  2*WIDTH       read data, valid when a done bit pulses after a read
//  hb_adr         out  32            to controller adr_i
//  hb_dat         out  2*WIDTH       to controller dat_i
//  hb_reg_space   out  1             to controller reg_space_i
//  hb_rrq/hb_wrq  out  1             to controller rrq/wrq; never both high
//  hb_busy        in   1             controller busy
//  hb_dat_i       in   2*WIDTH       controller dat_o
//  hb_error       in   1             controller error_o (sticky in controller)
//  fault          out  1             sticky arbiter fault (timeout or hb_error)
// BEHAVIOUR
//  Reset: state IDLE, gnt/done/err/hb_rrq/hb_wrq/fault=0, rdat/hb_adr/hb_dat=0, rr_ptr=NREQ-1.
//  All outputs registered. hb_* inputs sampled directly; no synchronisers.
//  Requester i is active when req_rrq[i]|req_wrq[i]. If both are set, read wins.
//  States: IDLE -> ISSUE -> ACTIVE -> IDLE. FAULT is terminal.
//  IDLE: the winner is the first active index searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//   Next edge: latch its adr/dat/reg_space into hb_*. Set hb_rrq or hb_wrq. Set gnt[winner].
//   Set rr_ptr=winner and timer=0. Go to ISSUE. If nothing is active, stay in IDLE with no outputs.
//   A request seen in IDLE must not be issued if hb_busy=1. Wait for hb_busy=0.
//  ISSUE: hold hb_* stable and timer++. When hb_busy=1, go to ACTIVE.
//   If timer reaches ACK_TIMEOUT with hb_busy still 0, go to FAULT.
//  ACTIVE: hold hb_rrq/hb_wrq stable, because the controller re-reads rrq to pick read/write.
//   When hb_busy falls to 0: drop hb_rrq/hb_wrq. For a read, rdat<=hb_dat_i.
//   Pulse done[winner] for 1 cycle, clear gnt, return to IDLE.
//   Arbitration resumes the cycle after done, so there is at least one idle cycle between grants.
//  hb_error=1 in any state except IDLE: pulse err[winner], clear gnt/hb_rrq/hb_wrq.
//   Set fault=1 and go to FAULT. hb_error wins over a simultaneous busy fall.
//  FAULT: all gnt=0 and hb_rrq=hb_wrq=0. Ignore requests. Leave only via rst.
//  Requester dropping its request mid-transaction: ignored; the transaction completes, done still pulses.
//  rst asserted mid-transaction: immediate return to reset values. The controller is reset by the same rst.
//  Fairness: with all requesters continuously active, grants rotate 0,1,..,NREQ-1,0,...
//  Timer width is clog2(ACK_TIMEOUT+1). It saturates and never wraps.
// TESTING
//  1 Reset: rst high 3 cycles -> every output 0; with req_rrq=2'b11 during reset, gnt stays 0.
//  2 Single read: req_rrq[0]=1, adr=32'h0000_1234; controller model busy 20 cycles, dat=16'hBEEF
//    -> hb_rrq=1 and gnt=2'b01 through busy; done[0] pulses once; rdat=16'hBEEF; hb_wrq never 1.
//  3 Round-robin: both requesters writing continuously, 6 transactions
//    -> grant order 0,1,0,1,0,1; hb_dat matches the granted req_dat each time.
//  4 Timeout: model never raises busy -> after 15 cycles fault=1, err pulse, gnt=0; later requests ignored.
//  5 Controller error: hb_error rises during ACTIVE on requester 1 -> err[1] pulses, done[1] stays 0, fault=1.
//  6 Mid-op reset: rst pulsed during ACTIVE -> outputs 0 next edge; after release a fresh read completes normally.

Source files
------------

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter that shares one HyperBus controller between NREQ masters.
// The winner's command is latched and rrq/wrq stay put until the controller finishes.
//
// state  | meaning
// IDLE   | pick the next active requester round-robin once hb_busy is low
// ISSUE  | command presented, waiting for the controller to raise busy
// ACTIVE | controller running; hold rrq/wrq until busy falls
// FAULT  | timeout or controller error seen; left only through rst
`timescale 1ns/1ps
module hyperbus_arbiter #(
   parameter int NREQ        = 2,
   parameter int WIDTH       = 8,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                    clk90,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_rrq,
   input  logic [NREQ-1:0]         req_wrq,
   input  logic [NREQ-1:0]         req_reg_space,
   input  logic [NREQ*32-1:0]      req_adr,
   input  logic [NREQ*2*WIDTH-1:0] req_dat,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [NREQ-1:0]         err,
   output logic [2*WIDTH-1:0]      rdat,
   output logic [31:0]             hb_adr,
   output logic [2*WIDTH-1:0]      hb_dat,
   output logic                    hb_reg_space,
   output logic                    hb_rrq,
   output logic                    hb_wrq,
   input  logic                    hb_busy,
   input  logic [2*WIDTH-1:0]      hb_dat_i,
   input  logic                    hb_error,
   output logic                    fault
);

   localparam int DW = 2*WIDTH;
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(ACK_TIMEOUT+1);
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT-1);
   localparam logic [TW-1:0] T_MAX  = TW'(ACK_TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_FAULT} state_t;

   state_t          state_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   win_q;
   logic [TW-1:0]   timer_q;
   logic [NREQ-1:0] gnt_q, done_q, err_q;
   logic [DW-1:0]   rdat_q, hb_dat_q;
   logic [31:0]     hb_adr_q;
   logic            hb_rs_q, hb_rrq_q, hb_wrq_q, fault_q;

   logic [NREQ-1:0] active;
   logic            win_found;
   logic [IW-1:0]   win_d;
   int              cand;
   logic            abort;

   assign active = req_rrq | req_wrq;

   // Search rr_ptr+1, rr_ptr+2, ... (mod NREQ); the first active index wins.
   always_comb begin
      win_found = 1'b0;
      win_d     = '0;
      cand      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!win_found && active[IW'(cand)]) begin
            win_found = 1'b1;
            win_d     = IW'(cand);
         end
      end
   end

   // A controller error beats a simultaneous busy fall; a late busy beats the timeout.
   always_comb begin
      abort = 1'b0;
      if (state_q == S_ISSUE)
         abort = hb_error || (!hb_busy && (timer_q >= T_LAST));
      else if (state_q == S_ACTIVE)
         abort = hb_error;
   end

   always_ff @(posedge clk90 or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= IW'(NREQ-1);
         win_q    <= '0;
         timer_q  <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         err_q    <= '0;
         rdat_q   <= '0;
         hb_adr_q <= '0;
         hb_dat_q <= '0;
         hb_rs_q  <= 1'b0;
         hb_rrq_q <= 1'b0;
         hb_wrq_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         done_q <= '0;
         err_q  <= '0;
         if (abort) begin
            err_q[win_q] <= 1'b1;
            gnt_q        <= '0;
            hb_rrq_q     <= 1'b0;
            hb_wrq_q     <= 1'b0;
            fault_q      <= 1'b1;
            state_q      <= S_FAULT;
            if (state_q == S_ISSUE && !hb_error) timer_q <= T_MAX;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (win_found && !hb_busy) begin
                     hb_adr_q     <= req_adr[32*win_d +: 32];
                     hb_dat_q     <= req_dat[DW*win_d +: DW];
                     hb_rs_q      <= req_reg_space[win_d];
                     hb_rrq_q     <= req_rrq[win_d];
                     hb_wrq_q     <= ~req_rrq[win_d];
                     gnt_q        <= '0;
                     gnt_q[win_d] <= 1'b1;
                     rr_ptr_q     <= win_d;
                     win_q        <= win_d;
                     timer_q      <= '0;
                     state_q      <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (hb_busy) state_q <= S_ACTIVE;
                  else         timer_q <= timer_q + 1'b1;
               end
               S_ACTIVE: begin
                  if (!hb_busy) begin
                     if (hb_rrq_q) rdat_q <= hb_dat_i;
                     hb_rrq_q      <= 1'b0;
                     hb_wrq_q      <= 1'b0;
                     done_q[win_q] <= 1'b1;
                     gnt_q         <= '0;
                     state_q       <= S_IDLE;
                  end
               end
               default: begin
                  gnt_q    <= '0;
                  hb_rrq_q <= 1'b0;
                  hb_wrq_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign gnt          = gnt_q;
   assign done         = done_q;
   assign err          = err_q;
   assign rdat         = rdat_q;
   assign hb_adr       = hb_adr_q;
   assign hb_dat       = hb_dat_q;
   assign hb_reg_space = hb_rs_q;
   assign hb_rrq       = hb_rrq_q;
   assign hb_wrq       = hb_wrq_q;
   assign fault        = fault_q;

endmodule
